int_ctrl: RTL

- Interrupt controller that sits directly upstream of the CPU datapath (cd).
- Takes four asynchronous external interrupt request lines and synchronises and edge-detects them.
- Latches pending requests, applies a software mask and a global enable, and arbitrates by fixed priority.
- Drives the datapath's one-hot ie1..ie4 inputs with a single-cycle pulse, then blocks further interrupts until the control unit signals return-from-interrupt.

---
 rtl/int_ctrl_pkg.sv | 13 +
 rtl/int_sync.sv | 27 ++
 rtl/int_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
package int_ctrl_pkg;

  localparam int unsigned NIRQ  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/int_sync.sv
// Multi-stage synchroniser plus rising-edge detector for one request line.
module int_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the async input through the chain; keep one cycle of history for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: sync/edge-detect, pending latch, mask, fixed priority,
// single-cycle one-hot pulse to the datapath and block until return-from-interrupt.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned     SYNC_STAGES = 2,
  parameter logic [NIRQ-1:0] MASK_RESET  = 4'b1111
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            gie,
  input  logic            hold,
  input  logic            reti,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_in,
  output logic            ie1,
  output logic            ie2,
  output logic            ie3,
  output logic            ie4,
  output logic [NIRQ-1:0] pending,
  output logic [NIRQ-1:0] mask,
  output logic            in_service
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NIRQ-1:0]  ie_q, ie_d;
  logic             in_service_d;
  logic [NIRQ-1:0]  rise_c;
  logic [NIRQ-1:0]  clr_c;
  logic [NIRQ-1:0]  elig_c;
  logic [SEL_W-1:0] win_c;
  logic             found_c;

  // One synchroniser/edge detector per request line.
  for (genvar i = 0; i < NIRQ; i++) begin : g_sync
    int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .d      (irq[i]),
      .rise_c (rise_c[i])
    );
  end

  // Fixed-priority pick: lowest eligible index wins.
  always_comb begin
    elig_c  = pending & mask;
    win_c   = '0;
    found_c = 1'b0;
    for (int i = 0; i < NIRQ; i++) begin
      if (!found_c && elig_c[i]) begin
        win_c   = SEL_W'(i);
        found_c = 1'b1;
      end
    end
  end

  // Next state, pending clear and next registered outputs.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    clr_c        = '0;
    ie_d         = '0;
    in_service_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (gie && !hold && found_c) begin
          state_d = FIRE;
          sel_d   = win_c;
          clr_c   = NIRQ'(1) << win_c;
        end
      end
      FIRE:    state_d = SERVICE;
      SERVICE: if (reti) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == FIRE) ie_d = NIRQ'(1) << sel_d;
    in_service_d = (state_d != IDLE);
  end

  // State, selection, outputs, pending and mask registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      ie_q       <= '0;
      in_service <= 1'b0;
      pending    <= '0;
      mask       <= MASK_RESET;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ie_q       <= ie_d;
      in_service <= in_service_d;
      pending    <= (pending & ~clr_c) | rise_c;
      if (mask_we) mask <= mask_in;
    end
  end

  assign ie1 = ie_q[0];
  assign ie2 = ie_q[1];
  assign ie3 = ie_q[2];
  assign ie4 = ie_q[3];

endmodule
